// File: rtl/sobel_grad_sq.sv
// Streaming 3x3 Sobel stage producing gx^2+gy^2 for each interior pixel.
// Define SOBEL_GXGY_OUT_EN to also export the aligned gx/gy values.
module sobel_grad_sq #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = 8
) (
  input  logic                 clk_main,
  input  logic                 sys_rst_n,
  input  logic                 pix_valid,
  input  logic [PIX_W-1:0]     pix_data,
  input  logic                 pix_sof,
  output logic                 mag_valid,
  output logic [2*PIX_W+4:0]   mag_sq,
  output logic                 mag_sof,
  output logic                 mag_eol
`ifdef SOBEL_GXGY_OUT_EN
  ,
  output logic signed [PIX_W+2:0] gx_out,
  output logic signed [PIX_W+2:0] gy_out
`endif
);

  localparam int GW = PIX_W + 3;
  localparam int OW = 2 * PIX_W + 5;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col, cur_c;
  logic [RW-1:0] row, cur_r;

  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] w [3][3];

  logic v1, sof1, eol1;
  logic v2, sof2, eol2;
  logic signed [GW-1:0] gx_c, gy_c, gx_r, gy_r;
  logic signed [2*GW-1:0] gx2, gy2;
  logic [OW-1:0] sum_c;

  function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({3'b000, p});
  endfunction

  // pix_sof overrides the counters so a new frame can start at any time
  always_comb begin
    cur_c = pix_sof ? '0 : col;
    cur_r = pix_sof ? '0 : row;
  end

  always_ff @(posedge clk_main) begin
    if (!sys_rst_n) begin
      col <= '0;
      row <= '0;
    end else if (pix_valid) begin
      if (cur_c == COL_LAST) begin
        col <= '0;
        row <= (cur_r == ROW_LAST) ? '0 : cur_r + 1'b1;
      end else begin
        col <= cur_c + 1'b1;
        row <= cur_r;
      end
    end
  end

  // lb0 holds the previous line, lb1 the line before it
  always_ff @(posedge clk_main) begin
    if (pix_valid) begin
      lb0[cur_c] <= pix_data;
      lb1[cur_c] <= lb0[cur_c];
      for (int i = 0; i < 3; i++) begin
        w[i][0] <= w[i][1];
        w[i][1] <= w[i][2];
      end
      w[0][2] <= lb1[cur_c];
      w[1][2] <= lb0[cur_c];
      w[2][2] <= pix_data;
    end
  end

  always_comb begin
    gx_c = (ext(w[0][2]) + (ext(w[1][2]) <<< 1) + ext(w[2][2]))
         - (ext(w[0][0]) + (ext(w[1][0]) <<< 1) + ext(w[2][0]));
    gy_c = (ext(w[2][0]) + (ext(w[2][1]) <<< 1) + ext(w[2][2]))
         - (ext(w[0][0]) + (ext(w[0][1]) <<< 1) + ext(w[0][2]));
    gx2 = gx_r * gx_r;
    gy2 = gy_r * gy_r;
    sum_c = OW'(gx2) + OW'(gy2);
  end

  always_ff @(posedge clk_main) begin
    if (!sys_rst_n) begin
      v1 <= 1'b0;
      sof1 <= 1'b0;
      eol1 <= 1'b0;
      v2 <= 1'b0;
      sof2 <= 1'b0;
      eol2 <= 1'b0;
      gx_r <= '0;
      gy_r <= '0;
      mag_valid <= 1'b0;
      mag_sq <= '0;
      mag_sof <= 1'b0;
      mag_eol <= 1'b0;
    end else begin
      v1 <= pix_valid && (cur_r > RW'(1)) && (cur_c > CW'(1));
      sof1 <= (cur_r == RW'(2)) && (cur_c == CW'(2));
      eol1 <= (cur_c == COL_LAST);
      v2 <= v1;
      sof2 <= v1 && sof1;
      eol2 <= v1 && eol1;
      gx_r <= gx_c;
      gy_r <= gy_c;
      mag_valid <= v2;
      mag_sq <= v2 ? sum_c : '0;
      mag_sof <= v2 && sof2;
      mag_eol <= v2 && eol2;
    end
  end

`ifdef SOBEL_GXGY_OUT_EN
  always_ff @(posedge clk_main) begin
    if (!sys_rst_n) begin
      gx_out <= '0;
      gy_out <= '0;
    end else begin
      gx_out <= v2 ? gx_r : '0;
      gy_out <= v2 ? gy_r : '0;
    end
  end
`endif

endmodule

// File: tb/tb_sobel_grad_sq.sv
// Scoreboard bench for sobel_grad_sq on an 8x6 image.
// Checks values, sof/eol flags and 3-cycle latency.
module tb_sobel_grad_sq;

  localparam int W = 8;
  localparam int H = 6;

  logic clk_main = 1'b0;
  logic sys_rst_n = 1'b0;
  logic pix_valid = 1'b0;
  logic [7:0] pix_data = '0;
  logic pix_sof = 1'b0;
  logic mag_valid;
  logic [20:0] mag_sq;
  logic mag_sof;
  logic mag_eol;
`ifdef SOBEL_GXGY_OUT_EN
  logic signed [10:0] gx_out;
  logic signed [10:0] gy_out;
`endif

  sobel_grad_sq #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk_main(clk_main),
    .sys_rst_n(sys_rst_n),
    .pix_valid(pix_valid),
    .pix_data(pix_data),
    .pix_sof(pix_sof),
    .mag_valid(mag_valid),
    .mag_sq(mag_sq),
    .mag_sof(mag_sof),
    .mag_eol(mag_eol)
`ifdef SOBEL_GXGY_OUT_EN
    ,
    .gx_out(gx_out),
    .gy_out(gy_out)
`endif
  );

  always #5 clk_main = ~clk_main;

  typedef struct {
    int mag;
    int gx;
    int gy;
    bit sof;
    bit eol;
    longint t;
  } exp_t;

  exp_t q[$];
  int img [H][W];
  longint cyc = 0;
  int checks = 0;
  int errors = 0;
  int nout = 0;
  int nbig = 0;
  int nmid = 0;
  bit mon_en = 1'b0;

  always @(posedge clk_main) cyc <= cyc + 1;

  always @(negedge clk_main) begin
    if (mon_en) begin
      checks++;
      if (mag_valid) begin
        nout++;
        if (mag_sq == 21'd1040400) nbig++;
        if (mag_sq == 21'd25600) nmid++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out cyc=%0d mag_sq=%0d required none",
                   cyc, mag_sq);
        end else begin
          exp_t e;
          bit bad;
          e = q.pop_front();
          bad = (mag_sq !== e.mag[20:0]) || (mag_sof !== e.sof) ||
                (mag_eol !== e.eol) || (cyc != e.t + 3);
`ifdef SOBEL_GXGY_OUT_EN
          bad = bad || (gx_out !== e.gx[10:0]) || (gy_out !== e.gy[10:0]);
`endif
          if (bad) begin
            errors++;
            $display("FAIL out cyc=%0d mag=%0d sof=%0b eol=%0b required cyc=%0d mag=%0d sof=%0b eol=%0b gx=%0d gy=%0d",
                     cyc, mag_sq, mag_sof, mag_eol, e.t + 3, e.mag,
                     e.sof, e.eol, e.gx, e.gy);
          end
        end
      end else begin
        bit bad;
        bad = (mag_sq !== '0) || (mag_sof !== 1'b0) || (mag_eol !== 1'b0);
`ifdef SOBEL_GXGY_OUT_EN
        bad = bad || (gx_out !== '0) || (gy_out !== '0);
`endif
        if (bad) begin
          errors++;
          $display("FAIL idle_zero cyc=%0d mag=%0d sof=%0b eol=%0b required 0",
                   cyc, mag_sq, mag_sof, mag_eol);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push_exp(input int r, input int c);
    exp_t e;
    int cr, cc;
    cr = r - 1;
    cc = c - 1;
    e.gx = (img[cr-1][cc+1] + 2*img[cr][cc+1] + img[cr+1][cc+1])
         - (img[cr-1][cc-1] + 2*img[cr][cc-1] + img[cr+1][cc-1]);
    e.gy = (img[cr+1][cc-1] + 2*img[cr+1][cc] + img[cr+1][cc+1])
         - (img[cr-1][cc-1] + 2*img[cr-1][cc] + img[cr-1][cc+1]);
    e.mag = e.gx*e.gx + e.gy*e.gy;
    e.sof = (r == 2) && (c == 2);
    e.eol = (c == W - 1);
    e.t = cyc;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    repeat (n) begin
      @(posedge clk_main);
      #1;
    end
  endtask

  task automatic send_frame(input bit sof, input int npix, input int gap);
    for (int k = 0; k < npix; k++) begin
      int r, c;
      r = k / W;
      c = k % W;
      while ($urandom_range(0, 9) < gap) idle(1);
      pix_valid = 1'b1;
      pix_sof = sof && (k == 0);
      pix_data = img[r][c][7:0];
      if (r >= 2 && c >= 2) push_exp(r, c);
      @(posedge clk_main);
      #1;
      pix_valid = 1'b0;
      pix_sof = 1'b0;
    end
  endtask

  task automatic clr_cnt();
    nout = 0;
    nbig = 0;
    nmid = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk_main);
    #1;
    sys_rst_n = 1'b1;
    mon_en = 1'b1;
    check("reset_mag_valid", int'(mag_valid), 0);
    check("reset_mag_sq", int'(mag_sq), 0);
    idle(2);

    foreach (img[r, c]) img[r][c] = 100;
    clr_cnt();
    send_frame(1'b1, W*H, 0);
    idle(6);
    check("flat_count", nout, 24);

    foreach (img[r, c]) img[r][c] = (c < 4) ? 0 : 255;
    clr_cnt();
    send_frame(1'b0, W*H, 0);
    idle(6);
    check("vedge_count", nout, 24);
    check("vedge_max_count", nbig, 8);

    foreach (img[r, c]) img[r][c] = (r < 3) ? 10 : 50;
    clr_cnt();
    send_frame(1'b1, W*H, 0);
    idle(6);
    check("hedge_count", nout, 24);
    check("hedge_25600_count", nmid, 12);

    foreach (img[r, c]) img[r][c] = (r*37 + c*53 + r*c*11) % 256;
    clr_cnt();
    send_frame(1'b1, W*H, 0);
    idle(6);
    check("ramp_nogap_count", nout, 24);
    clr_cnt();
    send_frame(1'b1, W*H, 4);
    idle(6);
    check("ramp_gap_count", nout, 24);

    foreach (img[r, c]) img[r][c] = 255 - ((r*29 + c*71) % 200);
    clr_cnt();
    send_frame(1'b1, 3*W + 2, 0);
    foreach (img[r, c]) img[r][c] = c * 20 + r * 3;
    send_frame(1'b1, W*H, 0);
    idle(6);
    check("abort_count", nout, 30);

    foreach (img[r, c]) img[r][c] = (r*13 + c*41) % 256;
    clr_cnt();
    send_frame(1'b1, 20, 0);
    sys_rst_n = 1'b0;
    @(posedge clk_main);
    #1;
    q.delete();
    sys_rst_n = 1'b1;
    check("rst_mag_valid", int'(mag_valid), 0);
    idle(3);
    check("rst_drop_count", nout, 0);
    send_frame(1'b0, W*H, 2);
    idle(6);
    check("rst_frame_count", nout, 24);
    check("queue_empty", q.size(), 0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sobel_grad_sq.md
Name: sobel_grad_sq

Overview:
- Streaming 3x3 Sobel stage that sits directly upstream of the combinational integer square-root block.
- Consumes a raster 8-bit grey pixel stream and buffers two image lines.
- Computes horizontal/vertical Sobel gradients and emits gx^2+gy^2 as a 21-bit radical per interior pixel.
- The 21-bit output feeds the square-root radical input unchanged; the square root then gives the gradient magnitude (11-bit q).

Parameters:
- IMG_W, 640, pixels per line (>=3).
- IMG_H, 480, lines per frame (>=3).
- PIX_W, 8, pixel width; output width is 2*PIX_W+5 (21 at default). Only the default is verified.

Ports:
- clk_main  in  1  single system clock, rising edge.
- sys_rst_n  in  1  reset, synchronous, active-low.
- pix_valid  in  1  pixel accepted this cycle (no backpressure; gaps allowed).
- pix_data  in  PIX_W  unsigned grey pixel.
- pix_sof  in  1  qualifies with pix_valid; marks pixel (0,0) of a frame.
- mag_valid  out  1  mag_sq valid this cycle.
- mag_sq  out  2*PIX_W+5  gx^2+gy^2, unsigned.
- mag_sof  out  1  high with the first output of a frame, centre (1,1).
- mag_eol  out  1  high with the last output of each line, centre column IMG_W-2.

Behaviour:
- Reset:
  - All outputs are 0; row/col counters are 0; window and pipeline valid bits are cleared.
  - Line-buffer RAM is not cleared; the row counter gates its use.
- Counters:
  - col advances 0..IMG_W-1 on each pix_valid. At IMG_W-1 it wraps to 0 and row increments.
  - At row IMG_H-1, col IMG_W-1, both wrap to 0: the next pixel is treated as (0,0) even without pix_sof.
- pix_sof:
  - Forces the accepted pixel to (0,0) regardless of counter state.
  - Mid-frame pix_sof aborts the current frame. Outputs already in the pipeline still drain.
- Line buffers: two IMG_W-deep buffers written on pix_valid. The 3x3 window shifts only on pix_valid; idle cycles hold the state.
- Kernel, with window p[i][j], i=row (0=top), j=col (0=left):
  - gx = (p02+2p12+p22) - (p00+2p10+p20)
  - gy = (p20+2p21+p22) - (p00+2p01+p02)
  - Both are signed PIX_W+3 bits; range ±1020 at default.
  - Squares are unsigned 2*PIX_W+4 bits. The sum is 2*PIX_W+5 bits: max 2*1040400 = 2080800 < 2^21, so no saturation is needed.
- Output set:
  - One output per interior centre (r,c), r in 1..IMG_H-2, c in 1..IMG_W-2.
  - That is (IMG_W-2)*(IMG_H-2) outputs per frame, in raster order. Border centres produce nothing.
- Latency:
  - The output for centre (r,c) is triggered by accepting pixel (r+1,c+1) in cycle T.
  - mag_valid is high in cycle T+3 exactly.
  - Pipeline: window update, gx/gy, squares+sum. Arithmetic stages run free, independent of later pix_valid gaps.
- Output timing:
  - mag_valid is high for one cycle per output.
  - mag_sq, mag_sof and mag_eol are 0 when mag_valid is low.
- Back-to-back: a pixel every cycle gives one output per cycle within interior spans; there are no internal stalls.
- Reset mid-frame: the synchronous reset takes effect at the next edge. In-flight outputs are dropped and counters return to 0.

Optional Feature:
- Macro SOBEL_GXGY_OUT_EN.
- Defined:
  - Adds output ports gx_out and gy_out, each signed PIX_W+3.
  - Both carry the gx/gy of the same centre as mag_sq, aligned with mag_valid.
  - Both are 0 at reset and when mag_valid is low.
- Undefined: the ports and their alignment registers are absent; all other behaviour is identical.

Test Plan (IMG_W=8, IMG_H=6, PIX_W=8):
- Flat frame, all pixels 100, continuous pix_valid with pix_sof on the first pixel:
  - exactly 24 mag_valid pulses, all mag_sq=0;
  - mag_sof on the first pulse;
  - mag_eol on every 6th pulse.
- Vertical edge, columns 0-3 = 0 and columns 4-7 = 255:
  - centres c=3 and c=4 give mag_sq=1040400 (gx=+1020, gy=0 with the feature enabled);
  - all other centres give 0.
- Horizontal edge, rows 0-2 = 10 and rows 3-5 = 50:
  - centres in rows 2 and 3 give mag_sq=25600 (gy=+160);
  - rows 1 and 4 give 0.
- Random pix_valid gaps (about 40% idle):
  - every mag_valid lands exactly 3 cycles after acceptance of pixel (r+1,c+1);
  - mag_sq values match the gap-free run of the same frame.
- pix_sof asserted at pixel (3,2) mid-frame, then a full frame follows:
  - no output ever combines pixels from both frames;
  - the new frame yields 24 outputs with mag_sof on its first.
- sys_rst_n low for 1 cycle mid-frame:
  - the next cycle shows all outputs 0 and no further mag_valid until a new frame reaches pixel (2,2).
